// File: rtl/beef_branch_unit.sv
// rtl/beef_branch_unit.sv - structured loop/branch sequencer for the BEEF core
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous active-high reset
//   insn_valid     qualifies insn/pc this cycle
//   insn, pc       instruction and its address
//   acc_zero       accumulator-is-zero flag from the core
//   skip           combinational: core must not execute insn this cycle
//   pc_load        registered one-cycle PC load request (STALL cycle)
//   pc_target      registered PC load address, held between loads
//   state          CORE=00 BRANCH=01 STALL=10 ERROR=11
//   loop_level     number of occupied loop-return stack entries
//   err_overflow   sticky: stack or nesting counter overflow
//   err_underflow  sticky: CBB with empty stack
module beef_branch_unit #(
  parameter int             INSN_W     = 9,
  parameter int             PC_W       = 16,
  parameter int             LOOP_DEPTH = 8,
  parameter int             NEST_W     = 8,
  parameter logic [INSN_W-1:0] OP_CBF  = 9'b111110110,
  parameter logic [INSN_W-1:0] OP_CBB  = 9'b100110111
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              insn_valid,
  input  logic [INSN_W-1:0]                 insn,
  input  logic [PC_W-1:0]                   pc,
  input  logic                              acc_zero,
  output logic                              skip,
  output logic                              pc_load,
  output logic [PC_W-1:0]                   pc_target,
  output logic [1:0]                        state,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]   loop_level,
  output logic                              err_overflow,
  output logic                              err_underflow
);

  localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = $clog2(LOOP_DEPTH);

  typedef enum logic [1:0] {
    S_CORE   = 2'b00,
    S_BRANCH = 2'b01,
    S_STALL  = 2'b10,
    S_ERROR  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LVL_W-1:0]    r_level;
  logic [NEST_W-1:0]   r_nest;
  logic [NEST_W-1:0]   w_nest_nxt;
  logic [PC_W-1:0]     r_stack [LOOP_DEPTH];
  logic                r_pc_load;
  logic [PC_W-1:0]     r_pc_target;
  logic                r_err_ovf;
  logic                r_err_unf;

  logic                w_is_cbf;
  logic                w_is_cbb;
  logic                w_full;
  logic                w_empty;
  logic [IDX_W-1:0]    w_top_idx;
  logic [IDX_W-1:0]    w_push_idx;
  logic [PC_W-1:0]     w_return_pc;
  logic                w_push;
  logic                w_pop;
  logic                w_load;
  logic                w_set_ovf;
  logic                w_set_unf;
  logic                w_skip;

  assign w_is_cbf    = (insn == OP_CBF);
  assign w_is_cbb    = (insn == OP_CBB);
  assign w_full      = (r_level == LVL_W'(LOOP_DEPTH));
  assign w_empty     = (r_level == '0);
  // Top index is only used when the stack is non-empty, so the wrap at 0 is harmless.
  assign w_top_idx   = IDX_W'(r_level - LVL_W'(1));
  assign w_push_idx  = IDX_W'(r_level);
  assign w_return_pc = pc + PC_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_nest_nxt  = r_nest;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    w_skip      = 1'b0;
    case (r_state)
      S_CORE: begin
        if (insn_valid) begin
          if (w_is_cbf) begin
            if (acc_zero) begin
              // Loop body is not entered: scan forward to the matching CBB.
              w_nest_nxt  = NEST_W'(1);
              w_skip      = 1'b1;
              w_state_nxt = S_BRANCH;
            end else if (w_full) begin
              w_set_ovf   = 1'b1;
              w_state_nxt = S_ERROR;
            end else begin
              w_push = 1'b1;
            end
          end else if (w_is_cbb) begin
            if (w_empty) begin
              w_set_unf   = 1'b1;
              w_state_nxt = S_ERROR;
            end else if (acc_zero) begin
              w_pop = 1'b1;
            end else begin
              // Loop again: top entry stays for the next iteration.
              w_load      = 1'b1;
              w_state_nxt = S_STALL;
            end
          end
        end
      end
      S_BRANCH: begin
        w_skip = 1'b1;
        if (insn_valid) begin
          if (w_is_cbf) begin
            if (r_nest == '1) begin
              w_set_ovf   = 1'b1;
              w_state_nxt = S_ERROR;
            end else begin
              w_nest_nxt = r_nest + NEST_W'(1);
            end
          end else if (w_is_cbb) begin
            w_nest_nxt = r_nest - NEST_W'(1);
            if (r_nest == NEST_W'(1)) begin
              w_state_nxt = S_CORE;
            end
          end
        end
      end
      S_STALL: begin
        w_skip      = 1'b1;
        w_state_nxt = S_CORE;
      end
      default: begin
        w_skip = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CORE;
      r_level     <= '0;
      r_nest      <= '0;
      r_pc_load   <= 1'b0;
      r_pc_target <= '0;
      r_err_ovf   <= 1'b0;
      r_err_unf   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_nest    <= w_nest_nxt;
      r_pc_load <= w_load;
      if (w_load) begin
        r_pc_target <= r_stack[w_top_idx];
      end
      if (w_push) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_set_ovf) begin
        r_err_ovf <= 1'b1;
      end
      if (w_set_unf) begin
        r_err_unf <= 1'b1;
      end
    end
  end

  // Entry contents need no reset: loop_level alone defines which are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_return_pc;
    end
  end

  assign skip          = w_skip;
  assign pc_load       = r_pc_load;
  assign pc_target     = r_pc_target;
  assign state         = r_state;
  assign loop_level    = r_level;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

endmodule

// File: tb/tb_beef_branch_unit.sv
// tb/tb_beef_branch_unit.sv - scoreboard bench for beef_branch_unit
module tb_beef_branch_unit;

  localparam logic [8:0] CBF = 9'b111110110;
  localparam logic [8:0] CBB = 9'b100110111;
  localparam logic [8:0] NOP = 9'h001;
  localparam int DEPTH    = 8;
  localparam int NEST_MAX = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        insn_valid = 1'b0;
  logic [8:0]  insn = '0;
  logic [15:0] pc = '0;
  logic        acc_zero = 1'b0;
  logic        skip;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [1:0]  state;
  logic [3:0]  loop_level;
  logic        err_overflow;
  logic        err_underflow;

  always #5 clk = ~clk;

  beef_branch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .insn_valid   (insn_valid),
    .insn         (insn),
    .pc           (pc),
    .acc_zero     (acc_zero),
    .skip         (skip),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .state        (state),
    .loop_level   (loop_level),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  typedef struct packed {
    logic        skip;
    logic        pc_load;
    logic [15:0] tgt;
    logic [1:0]  st;
    logic [3:0]  lvl;
    logic        ovf;
    logic        unf;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle_no = 0;

  // Reference model: 0=CORE 1=BRANCH 2=STALL 3=ERROR
  int   m_st;
  int   m_nest;
  int   m_stack[$];
  bit   m_load;
  int   m_tgt;
  bit   m_ovf;
  bit   m_unf;

  function automatic void model_reset();
    m_st = 0; m_nest = 0; m_stack.delete(); m_load = 0; m_tgt = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic obs_t model_obs(bit v, logic [8:0] ins, bit az);
    obs_t o;
    o.skip    = (m_st == 0) ? (v && ins == CBF && az) : 1'b1;
    o.pc_load = m_load;
    o.tgt     = m_tgt[15:0];
    o.st      = m_st[1:0];
    o.lvl     = 4'(m_stack.size());
    o.ovf     = m_ovf;
    o.unf     = m_unf;
    return o;
  endfunction

  function automatic void model_step(bit v, logic [8:0] ins, int p, bit az);
    bit nl = 0;
    case (m_st)
      0: if (v) begin
        if (ins == CBF) begin
          if (az) begin m_nest = 1; m_st = 1; end
          else if (m_stack.size() == DEPTH) begin m_ovf = 1; m_st = 3; end
          else m_stack.push_back((p + 1) % 65536);
        end else if (ins == CBB) begin
          if (m_stack.size() == 0) begin m_unf = 1; m_st = 3; end
          else if (az) void'(m_stack.pop_back());
          else begin m_tgt = m_stack[$]; nl = 1; m_st = 2; end
        end
      end
      1: if (v) begin
        if (ins == CBF) begin
          if (m_nest == NEST_MAX) begin m_ovf = 1; m_st = 3; end
          else m_nest++;
        end else if (ins == CBB) begin
          m_nest--;
          if (m_nest == 0) m_st = 0;
        end
      end
      2: m_st = 0;
      default: ;
    endcase
    m_load = nl;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    insn_valid = 1'b0;
    model_reset();
    exp_q.push_back(model_obs(1'b0, '0, 1'b0));
  endtask

  task automatic step(bit v, logic [8:0] ins, int p, bit az);
    @(posedge clk); #1;
    reset = 1'b0;
    insn_valid = v; insn = ins; pc = p[15:0]; acc_zero = az;
    exp_q.push_back(model_obs(v, ins, az));
    model_step(v, ins, p, az);
  endtask

  function automatic logic [8:0] rand_other();
    logic [8:0] r;
    do r = 9'($urandom_range(0, 511)); while (r == CBF || r == CBB);
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = '{skip, pc_load, pc_target, state, loop_level, err_overflow, err_underflow};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL obs cycle %0d: actual skip=%b load=%b tgt=%h st=%0d lvl=%0d ovf=%b unf=%b, required skip=%b load=%b tgt=%h st=%0d lvl=%0d ovf=%b unf=%b",
                 cycle_no, a.skip, a.pc_load, a.tgt, a.st, a.lvl, a.ovf, a.unf,
                 e.skip, e.pc_load, e.tgt, e.st, e.lvl, e.ovf, e.unf);
      end
      cycle_no++;
    end
  end

  initial begin
    model_reset();
    // Basic loop back with STALL
    do_reset();
    step(1, CBF, 'h0010, 0);
    step(1, NOP, 'h0011, 0);
    step(1, CBB, 'h0014, 0);
    step(1, NOP, 'h0015, 1);
    step(0, NOP, 'h0011, 0);
    step(1, CBB, 'h0014, 1);
    step(1, NOP, 'h0015, 0);
    // Forward scan with nesting
    do_reset();
    step(1, CBF, 'h0020, 1);
    step(1, CBF, 'h0021, 0);
    step(1, NOP, 'h0022, 0);
    step(1, CBB, 'h0023, 0);
    step(0, CBB, 'h0024, 0);
    step(1, CBB, 'h0024, 0);
    step(1, NOP, 'h0025, 0);
    // Stack overflow
    do_reset();
    for (int i = 0; i < 9; i++) step(1, CBF, 'h0100 + i, 0);
    step(1, NOP, 'h0200, 0);
    step(0, NOP, 'h0201, 0);
    // Underflow
    do_reset();
    step(1, CBB, 'h0300, 1);
    step(1, CBB, 'h0301, 0);
    step(0, NOP, 'h0302, 0);
    // PC wrap
    do_reset();
    step(1, CBF, 'hFFFF, 0);
    step(1, CBB, 'h0000, 0);
    step(1, NOP, 'h0001, 0);
    step(1, NOP, 'h0000, 0);
    // Reset mid-BRANCH
    do_reset();
    step(1, CBF, 'h0400, 0);
    step(1, CBF, 'h0401, 0);
    step(1, CBF, 'h0402, 1);
    step(1, CBF, 'h0403, 0);
    step(1, CBF, 'h0404, 0);
    do_reset();
    step(1, CBB, 'h0405, 0);
    step(0, NOP, 'h0406, 0);
    // Reset mid-STALL
    do_reset();
    step(1, CBF, 'h0500, 0);
    step(1, CBB, 'h0501, 0);
    do_reset();
    step(1, NOP, 'h0502, 0);
    // Nesting counter overflow
    do_reset();
    step(1, CBF, 'h0600, 1);
    for (int i = 0; i < NEST_MAX - 1; i++) step(1, CBF, 'h0601 + i, 0);
    step(1, CBF, 'h0700, 0);
    step(1, CBB, 'h0701, 0);
    // Randomised segments
    for (int s = 0; s < 20; s++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        int r;
        logic [8:0] ins;
        r = $urandom_range(0, 99);
        ins = (r < 35) ? CBF : (r < 60) ? CBB : rand_other();
        step(($urandom_range(0, 9) < 8), ins, $urandom_range(0, 65535), ($urandom_range(0, 9) < 3));
      end
    end
    @(posedge clk); #1;
    insn_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beef_branch_unit.md
BEEF_BRANCH_UNIT -- requirements
Module: beef_branch_unit

Interface
REQ-001 Parameter INSN_W, default 9, SHALL set the instruction width in bits.
REQ-002 Parameter PC_W, default 16, SHALL set the program counter width in bits.
REQ-003 Parameter LOOP_DEPTH, default 8, SHALL set the loop-return stack depth (entries, >=2).
REQ-004 Parameter NEST_W, default 8, SHALL set the forward-scan nesting counter width.
REQ-005 Parameter OP_CBF, default 9'b111110110, SHALL set the forward-branch opcode.
REQ-006 Parameter OP_CBB, default 9'b100110111, SHALL set the backward-branch opcode.
REQ-007 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-008 Port clk, input, 1, SHALL be the sole clock; all state updates on rising edge.
REQ-009 Port reset, input, 1, SHALL be the asynchronous active-high reset.
REQ-010 Port insn_valid, input, 1, SHALL qualify insn and pc for the current cycle.
REQ-011 Port insn, input, INSN_W, SHALL carry the instruction at pc.
REQ-012 Port pc, input, PC_W, SHALL carry the address of insn.
REQ-013 Port acc_zero, input, 1, SHALL be high when the accumulator is zero.
REQ-014 Port skip, output, 1, SHALL tell the core not to execute insn this cycle (combinational).
REQ-015 Port pc_load, output, 1, SHALL request a PC load (registered, one-cycle pulse).
REQ-016 Port pc_target, output, PC_W, SHALL carry the load address (registered).
REQ-017 Port state, output, 2, SHALL encode CORE=00, BRANCH=01, STALL=10, ERROR=11.
REQ-018 Port loop_level, output, $clog2(LOOP_DEPTH+1), SHALL report occupied stack entries.
REQ-019 Port err_overflow and err_underflow, output, 1 each, SHALL be sticky error flags.

Function
REQ-020 An instruction SHALL be accepted only when insn_valid=1 and state is CORE or BRANCH.
REQ-021 CORE, CBF, acc_zero=0: SHALL push pc+1 (modulo 2^PC_W) onto the stack; skip=0; stay CORE.
REQ-022 CORE, CBF, acc_zero=1: SHALL set nest=1, assert skip, enter BRANCH next cycle; no push.
REQ-023 CORE, CBB, acc_zero=0: SHALL, next cycle, drive pc_load=1 with pc_target=top of stack (no pop) and enter STALL; skip=0.
REQ-024 CORE, CBB, acc_zero=1: SHALL pop one entry; skip=0; stay CORE.
REQ-025 CORE, other opcodes: SHALL leave all state unchanged; skip=0.
REQ-026 BRANCH: every accepted instruction SHALL have skip=1; stack unchanged.
REQ-027 BRANCH, CBF: nest SHALL increment; if nest is already 2^NEST_W-1, SHALL set err_overflow and enter ERROR.
REQ-028 BRANCH, CBB: nest SHALL decrement; when it reaches 0, SHALL enter CORE next cycle (that CBB skipped).
REQ-029 STALL SHALL last exactly one cycle, ignore insn_valid, assert skip=1, then enter CORE.
REQ-030 pc_load SHALL be high only during the STALL cycle; pc_target SHALL hold its last value otherwise.
REQ-031 CBF push with loop_level=LOOP_DEPTH SHALL set err_overflow, not push, and enter ERROR.
REQ-032 CBB (either acc_zero value) with loop_level=0 in CORE SHALL set err_underflow and enter ERROR; no pc_load.
REQ-033 ERROR SHALL be terminal until reset; skip=1, pc_load=0, stack frozen.
REQ-034 skip with insn_valid=0 SHALL be 0 in CORE and 1 in BRANCH, STALL and ERROR.

Reset
REQ-035 Reset assertion SHALL immediately force state=CORE, loop_level=0, nest=0, pc_load=0, pc_target=0, err_overflow=0, err_underflow=0.
REQ-036 Reset asserted mid-BRANCH or mid-STALL SHALL discard scan and stack contents; no pending pc_load SHALL survive.

Verification
REQ-037 CBF@pc=0x0010 acc_zero=0, then CBB@0x0014 acc_zero=0 -> loop_level 1, next cycle pc_load=1, pc_target=0x0011, state STALL, then CORE.
REQ-038 CBF@0x0020 acc_zero=1, then stream CBF, INC, CBB, CBB -> skip=1 on all five, nest 1->2->2->1->0, state CORE after the last CBB, loop_level 0.
REQ-039 LOOP_DEPTH=8: nine CBF with acc_zero=0 -> loop_level 8, err_overflow=1 on the ninth, state ERROR, later insns skipped.
REQ-040 CBB with acc_zero=1 at loop_level=0 -> err_underflow=1, state ERROR, pc_load never asserted.
REQ-041 CBF@0xFFFF acc_zero=0, CBB acc_zero=0 -> pc_target=0x0000 (wrap).
REQ-042 Reset pulsed during BRANCH with nest=3, loop_level=2 -> all outputs at reset values immediately; next CBB at loop_level 0 flags err_underflow.
